sync_fifo_prog: RTL and testbench
=================================

Name: sync_fifo_prog

Overview:
Parametrised synchronous FIFO, next generation of the team's single-clock FIFO.
- Adds generic width and depth, run-time programmable almost-full/almost-empty thresholds, a fill-level output, and sticky overflow/underflow error flags with clear.
- Sits between producer and consumer blocks in one clock domain.
- Driven and monitored through the existing fifo_if style of driver and monitor clocking blocks.

Parameters:
- DATA_W, 8: word width in bits.
- DEPTH, 16: number of entries; power of two, at least 4.
- CNT_W, $clog2(DEPTH+1): width of fill count and thresholds (derived; do not override).

Ports:
- clk, in, 1: single clock, rising edge.
- rstn, in, 1: reset, asynchronous, active-low.
- i_wren, in, 1: write request.
- i_wrdata, in, DATA_W: write data.
- i_rden, in, 1: read request.
- o_rddata, out, DATA_W: read data.
- i_alm_full_thr, in, CNT_W: almost-full threshold (quasi-static).
- i_alm_empty_thr, in, CNT_W: almost-empty threshold (quasi-static).
- i_clr_err, in, 1: synchronous clear of the sticky error flags.
- o_count, out, CNT_W: current fill level, 0..DEPTH.
- o_empty, out, 1: count == 0.
- o_alm_empty, out, 1: count <= i_alm_empty_thr.
- o_full, out, 1: count == DEPTH.
- o_alm_full, out, 1: count >= i_alm_full_thr.
- o_overflow, out, 1: sticky; a write was attempted while full and not accepted.
- o_underflow, out, 1: sticky; a read was attempted while empty.

Behaviour:
- Reset (rstn low, asynchronous): pointers = 0, count = 0, o_rddata = 0, o_empty = 1, o_alm_empty = 1, o_full = 0, o_alm_full = 0, o_overflow = 0, o_underflow = 0. Memory contents are not reset.
- Reset mid-operation: all stored data is discarded and the FIFO restarts empty. The first write after rstn rises is accepted on the first rising clk edge.
- Accept rules, evaluated on the current registered state:
  - wr_ok = i_wren & (!o_full | i_rden).
  - rd_ok = i_rden & !o_empty.
- Full with simultaneous read and write: both are accepted and count is unchanged.
- Empty with simultaneous read and write: the write is accepted, the read is rejected, and o_underflow is set.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Count update: count_next = count + wr_ok - rd_ok.
- All flags and o_count are registered and computed from count_next, so they update in the same cycle as count, one clock after the accepted operation.
- Read latency (standard mode):
  - o_rddata is updated on the clock edge where rd_ok is true, with mem[rd_ptr].
  - Data is valid the cycle after i_rden was sampled.
  - o_rddata holds its value when no read is accepted.
- Write-to-read: a word written at edge N is readable at edge N+1, where o_empty has gone low.
- Errors:
  - i_wren & o_full & !i_rden sets o_overflow; the data is dropped and state is unchanged.
  - i_rden & o_empty sets o_underflow.
  - i_clr_err clears both flags on the next edge.
  - If clear and a new error occur in the same cycle, set wins.
- Thresholds:
  - A threshold of 0 gives o_alm_full always 1.
  - i_alm_empty_thr >= DEPTH gives o_alm_empty always 1.
  - A threshold change takes effect at the next edge.
- No state machine beyond pointer/count registers. The error flags are 2 independent set/clear registers.

Optional Feature:
Macro SYNC_FIFO_FWFT_EN.
- Defined (first-word fall-through):
  - o_rddata continuously presents the head word whenever o_empty is low.
  - i_rden with !o_empty pops the head; the next word appears at the following edge.
  - A word written into an empty FIFO is visible on o_rddata in the same cycle o_empty deasserts.
  - Count, flags and error rules are unchanged.
- Not defined: the standard registered-read behaviour above applies, with one-cycle latency.

Decomposition:
- Package sync_fifo_pkg:
  - DATA_W default constant (shared with fifo_if).
  - DEPTH default constant.
  - typedef data_t, logic [DATA_W-1:0].
  - typedef cnt_t for count and thresholds.
- Sub-module sync_fifo_mem:
  - Simple dual-port register array, one write port and one read port.
  - Synchronous write; read port is registered (standard) or combinational (FWFT).
- Pointer, count, flag and error logic stay in sync_fifo_prog.

Test Plan:
All tests use DATA_W=8 and DEPTH=16.
1. Reset mid-stream: write 5 words, pull rstn low for 1 cycle → o_count=0, o_empty=1, o_alm_empty=1, o_rddata=0; the next read sets o_underflow.
2. Fill/drain ordering: write 0x00..0x0F → o_full=1 after the 16th edge, o_count=16; read 16 → data 0x00..0x0F in order, one cycle latency, o_empty=1.
3. Thresholds: alm_full_thr=12, alm_empty_thr=3; write 12 → o_alm_full rises on the 12th write's next edge; read down to 3 → o_alm_empty=1, and it is 0 at count 4.
4. Full with simultaneous read and write: at count 16 assert i_wren+i_rden with data 0xAA → count stays 16, no overflow, 0xAA emerges 16th in order.
5. Errors: at full, write 0x55 alone → o_overflow=1 and count 16; assert i_clr_err → 0 next edge; at empty assert rd+wr → write accepted, count=1, o_underflow=1.
6. Wrap-around plus FWFT_EN: 40 cycles of continuous rd/wr at count 8 with an incrementing pattern → no data loss, pointers wrap; under FWFT, o_rddata equals the head word whenever o_empty=0.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared constants and types for the programmable synchronous FIFO and its fifo_if users.
package sync_fifo_pkg;

    localparam int unsigned FIFO_DATA_W = 8;
    localparam int unsigned FIFO_DEPTH  = 16;
    localparam int unsigned FIFO_CNT_W  = $clog2(FIFO_DEPTH + 1);

    typedef logic [FIFO_DATA_W-1:0] data_t;
    typedef logic [FIFO_CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage for sync_fifo_prog: synchronous write, registered read port,
// or a combinational read port when SYNC_FIFO_FWFT_EN is defined.
module sync_fifo_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
`ifndef SYNC_FIFO_FWFT_EN
    input  logic              rst_ni,
    input  logic              rd_en_i,
`endif
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    // Storage is deliberately left out of reset.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rd_data_o = mem_q[rd_addr_i];
`else
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;
`endif

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/empty thresholds and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads; default is one-cycle read latency.
module sync_fifo_prog
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = FIFO_DATA_W,
    parameter int unsigned DEPTH  = FIFO_DEPTH,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_wren,
    input  logic [DATA_W-1:0] i_wrdata,
    input  logic              i_rden,
    output logic [DATA_W-1:0] o_rddata,
    input  logic [CNT_W-1:0]  i_alm_full_thr,
    input  logic [CNT_W-1:0]  i_alm_empty_thr,
    input  logic              i_clr_err,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_empty,
    output logic              o_alm_empty,
    output logic              o_full,
    output logic              o_alm_full,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam int unsigned     AW       = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              alm_empty_q, alm_empty_d;
    logic              alm_full_q, alm_full_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              wr_ok, rd_ok;
    logic [DATA_W-1:0] mem_rdata;

    always_comb begin
        // A write into a full FIFO is only safe when a read frees the slot in the same cycle.
        wr_ok = i_wren & (~full_q | i_rden);
        rd_ok = i_rden & ~empty_q;

        wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);

        empty_d     = (count_d == '0);
        full_d      = (count_d == FULL_CNT);
        alm_empty_d = (count_d <= i_alm_empty_thr);
        alm_full_d  = (count_d >= i_alm_full_thr);

        // New error beats a simultaneous clear.
        ovf_d = (i_wren & full_q & ~i_rden) | (ovf_q & ~i_clr_err);
        unf_d = (i_rden & empty_q) | (unf_q & ~i_clr_err);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            alm_empty_q <= 1'b1;
            alm_full_q  <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            alm_empty_q <= alm_empty_d;
            alm_full_q  <= alm_full_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    sync_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk_i     (clk),
`ifndef SYNC_FIFO_FWFT_EN
        .rst_ni    (rstn),
        .rd_en_i   (rd_ok),
`endif
        .wr_en_i   (wr_ok),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (i_wrdata),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (mem_rdata)
    );

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is stale memory while empty; present zero instead.
    assign o_rddata = empty_q ? '0 : mem_rdata;
`else
    assign o_rddata = mem_rdata;
`endif

    assign o_count     = count_q;
    assign o_empty     = empty_q;
    assign o_full      = full_q;
    assign o_alm_empty = alm_empty_q;
    assign o_alm_full  = alm_full_q;
    assign o_overflow  = ovf_q;
    assign o_underflow = unf_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Self-checking bench for sync_fifo_prog: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_sync_fifo_prog;

    localparam int DEPTH = 16;

    logic       clk   = 1'b0;
    logic       rstn  = 1'b0;
    logic       wren  = 1'b0;
    logic       rden  = 1'b0;
    logic       clr   = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic [4:0] afthr = 5'd12;
    logic [4:0] aethr = 5'd3;
    logic [7:0] rddata;
    logic [4:0] count;
    logic       empty, alm_empty, full, alm_full, ovf, unf;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0] mq[$];
    logic [7:0] m_rd;
    logic       m_ovf, m_unf, m_af, m_ae;

    sync_fifo_prog #(
        .DATA_W (8),
        .DEPTH  (DEPTH)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .i_wren          (wren),
        .i_wrdata        (wdata),
        .i_rden          (rden),
        .o_rddata        (rddata),
        .i_alm_full_thr  (afthr),
        .i_alm_empty_thr (aethr),
        .i_clr_err       (clr),
        .o_count         (count),
        .o_empty         (empty),
        .o_alm_empty     (alm_empty),
        .o_full          (full),
        .o_alm_full      (alm_full),
        .o_overflow      (ovf),
        .o_underflow     (unf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_rd  = 8'h00;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_af  = 1'b0;
        m_ae  = 1'b1;
    endfunction

    function automatic void model_step(input logic we, input logic [7:0] wd, input logic re,
                                       input logic c);
        int sz   = mq.size();
        bit mful = (sz == DEPTH);
        bit memp = (sz == 0);
        bit wok  = we && (!mful || re);
        bit rok  = re && !memp;
        m_ovf = (we && mful && !re) || (m_ovf && !c);
        m_unf = (re && memp) || (m_unf && !c);
        if (rok) m_rd = mq.pop_front();
        if (wok) mq.push_back(wd);
        m_af = (mq.size() >= int'(afthr));
        m_ae = (mq.size() <= int'(aethr));
    endfunction

    function automatic void check_all(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(mq.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
        chk({tag, ".full"}, 32'(full), 32'(mq.size() == DEPTH));
        chk({tag, ".alm_full"}, 32'(alm_full), 32'(m_af));
        chk({tag, ".alm_empty"}, 32'(alm_empty), 32'(m_ae));
        chk({tag, ".overflow"}, 32'(ovf), 32'(m_ovf));
        chk({tag, ".underflow"}, 32'(unf), 32'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
        if (mq.size() != 0) chk({tag, ".rddata"}, 32'(rddata), 32'(mq[0]));
`else
        chk({tag, ".rddata"}, 32'(rddata), 32'(m_rd));
`endif
    endfunction

    task automatic cycle(input logic we, input logic [7:0] wd, input logic re, input logic c,
                         input string tag);
        wren  = we;
        wdata = wd;
        rden  = re;
        clr   = c;
        @(posedge clk);
        model_step(we, wd, re, c);
        #1;
        check_all(tag);
    endtask

    // Asserts reset asynchronously between edges, checks reset values, releases after one edge.
    task automatic do_reset(input string tag);
        rstn = 1'b0;
        wren = 1'b0;
        rden = 1'b0;
        clr  = 1'b0;
        #2;
        chk({tag, ".rst_count"}, 32'(count), 0);
        chk({tag, ".rst_empty"}, 32'(empty), 1);
        chk({tag, ".rst_alm_empty"}, 32'(alm_empty), 1);
        chk({tag, ".rst_full"}, 32'(full), 0);
        chk({tag, ".rst_alm_full"}, 32'(alm_full), 0);
        chk({tag, ".rst_ovf"}, 32'(ovf), 0);
        chk({tag, ".rst_unf"}, 32'(unf), 0);
        chk({tag, ".rst_rddata"}, 32'(rddata), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       re;
        logic       clr;
        int         exp_cnt;
        logic       exp_unf;
        logic [7:0] exp_rd;
        logic [7:0] exp_head;
    } vec_t;

    vec_t vecs[12];

    initial begin
        // Empty-side behaviour from a fresh reset, thresholds af=12 ae=3.
        vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h00, 8'h00};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 8'h00, 8'h00};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h00, 8'h00};
        vecs[3]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1, 1'b1, 8'h00, 8'h11};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 8'h00, 8'h11};
        vecs[5]  = '{1'b1, 8'h22, 1'b0, 1'b0, 2, 1'b0, 8'h00, 8'h11};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 8'h11, 8'h22};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h22, 8'h00};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b1, 8'h22, 8'h00};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 8'h22, 8'h00};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h22, 8'h00};
        vecs[11] = '{1'b1, 8'h33, 1'b0, 1'b0, 1, 1'b0, 8'h22, 8'h33};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            wren  = vecs[i].we;
            wdata = vecs[i].wd;
            rden  = vecs[i].re;
            clr   = vecs[i].clr;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d.empty", i), 32'(empty), 32'(vecs[i].exp_cnt == 0));
            chk($sformatf("vec%0d.alm_empty", i), 32'(alm_empty), 1);
            chk($sformatf("vec%0d.underflow", i), 32'(unf), 32'(vecs[i].exp_unf));
            chk($sformatf("vec%0d.overflow", i), 32'(ovf), 0);
`ifdef SYNC_FIFO_FWFT_EN
            if (vecs[i].exp_cnt != 0)
                chk($sformatf("vec%0d.rddata", i), 32'(rddata), 32'(vecs[i].exp_head));
`else
            chk($sformatf("vec%0d.rddata", i), 32'(rddata), 32'(vecs[i].exp_rd));
`endif
        end

        // Reset mid-stream discards data; next read underflows.
        do_reset("t1a");
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, "t1_wr");
        do_reset("t1b");
        cycle(1'b0, 8'h00, 1'b1, 1'b0, "t1_rd");
        chk("t1.underflow_after_reset", 32'(unf), 1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, "t1_clr");

        // Fill/drain ordering.
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, "t2_wr");
        chk("t2.full", 32'(full), 1);
        chk("t2.count16", 32'(count), 16);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0, "t2_rd");
`ifndef SYNC_FIFO_FWFT_EN
            chk("t2.order", 32'(rddata), 32'(i));
`endif
        end
        chk("t2.empty", 32'(empty), 1);

        // Thresholds af=12, ae=3.
        for (int i = 1; i <= 12; i++) begin
            cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, "t3_wr");
            if (i == 11) chk("t3.alm_full_at11", 32'(alm_full), 0);
            if (i == 12) chk("t3.alm_full_at12", 32'(alm_full), 1);
        end
        for (int n = 11; n >= 0; n--) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0, "t3_rd");
            if (n == 4) chk("t3.alm_empty_at4", 32'(alm_empty), 0);
            if (n == 3) chk("t3.alm_empty_at3", 32'(alm_empty), 1);
        end

        // Full with simultaneous read and write.
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, "t4_wr");
        cycle(1'b1, 8'hAA, 1'b1, 1'b0, "t4_rw");
        chk("t4.count_stays16", 32'(count), 16);
        chk("t4.no_overflow", 32'(ovf), 0);
        for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "t4_rd");
`ifndef SYNC_FIFO_FWFT_EN
        chk("t4.aa_last", 32'(rddata), 32'h0000_00AA);
`endif

        // Overflow, clear, then underflow with accepted write at empty.
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, "t5_wr");
        cycle(1'b1, 8'h55, 1'b0, 1'b0, "t5_ovf");
        chk("t5.overflow", 32'(ovf), 1);
        chk("t5.count16", 32'(count), 16);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, "t5_clr");
        chk("t5.overflow_cleared", 32'(ovf), 0);
        for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "t5_rd");
        cycle(1'b1, 8'h77, 1'b1, 1'b0, "t5_rw_empty");
        chk("t5.count1", 32'(count), 1);
        chk("t5.underflow", 32'(unf), 1);
        afthr = 5'd0;
        cycle(1'b0, 8'h00, 1'b1, 1'b1, "t5_thr0");
        chk("t5.alm_full_thr0_empty", 32'(alm_full), 1);
        afthr = 5'd12;

        // Wrap-around with continuous read/write at count 8.
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, "t6_wr");
        for (int i = 0; i < 40; i++) cycle(1'b1, 8'(8 + i), 1'b1, 1'b0, "t6_rw");
        chk("t6.count8", 32'(count), 8);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "t6_rd");

        // Randomized traffic with phase-varying bias and threshold changes.
        begin
            int pw = 50;
            int pr = 50;
            for (int i = 0; i < 3000; i++) begin
                if (i % 250 == 0) begin
                    pw = 20 + 30 * int'($urandom_range(0, 2));
                    pr = 20 + 30 * int'($urandom_range(0, 2));
                end
                if (i % 300 == 0) begin
                    afthr = 5'($urandom_range(0, 20));
                    aethr = 5'($urandom_range(0, 20));
                end
                if (i == 1700) do_reset("rnd");
                cycle(1'($urandom_range(0, 99) < pw), 8'($urandom), 1'($urandom_range(0, 99) < pr),
                      1'($urandom_range(0, 15) == 0), "rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
